spi_byte_queue: RTL and testbench

Buffered transfer controller placed directly upstream of the SPI byte engine. Accepts outgoing bytes from the processor into a TX FIFO, launches one SPI byte transfer per entry through the engine's `ready_send`/`busy` handshake, and pushes each received byte into an RX FIFO the processor drains. Adds overflow and engine-timeout error reporting.

---
 rtl/spi_byte_queue_if.sv | 36 +++
 rtl/spi_byte_queue.sv | 134 +++++++++++++
 tb/tb_spi_byte_queue.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_queue_if.sv
// Processor-side and engine-side signals of the SPI byte queue, bundled for port connection.
// slave is the queue's view; master is the view of the logic that drives the queue.
interface spi_byte_queue_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [7:0]    spi_data;
   logic          spi_start;
   logic          spi_busy;
   logic [7:0]    spi_rx;
   logic          err_clr;
   logic          rx_overflow;
   logic          err_timeout;
   logic [LW-1:0] tx_level;
   logic [LW-1:0] rx_level;
   logic          active;

   modport slave (
      input  tx_data, tx_valid, rx_ready, spi_busy, spi_rx, err_clr,
      output tx_ready, rx_data, rx_valid, spi_data, spi_start,
             rx_overflow, err_timeout, tx_level, rx_level, active
   );

   modport master (
      output tx_data, tx_valid, rx_ready, spi_busy, spi_rx, err_clr,
      input  tx_ready, rx_data, rx_valid, spi_data, spi_start,
             rx_overflow, err_timeout, tx_level, rx_level, active
   );
endinterface

// File: rtl/spi_byte_queue.sv
// TX/RX byte FIFOs around an SPI byte engine: one engine transfer per TX entry,
// each received byte pushed to RX, with sticky overflow and engine-timeout flags.
module spi_byte_queue #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   spi_byte_queue_if.slave    bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, CAPTURE} state_t;

   state_t        state;
   logic [7:0]    tx_mem [DEPTH];
   logic [7:0]    rx_mem [DEPTH];
   logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
   logic [LW-1:0] tx_cnt, rx_cnt;
   logic [TW-1:0] timer;
   logic [7:0]    spi_data;
   logic          spi_start;
   logic          rx_overflow;
   logic          err_timeout;

   logic tx_full, rx_full;
   logic tx_push, tx_pop, rx_push, rx_pop, rx_drop;

   assign tx_full = (tx_cnt == LW'(DEPTH));
   assign rx_full = (rx_cnt == LW'(DEPTH));
   assign tx_push = bus.tx_valid && !tx_full;
   assign tx_pop  = (state == IDLE) && (tx_cnt != '0);
   assign rx_pop  = (rx_cnt != '0) && bus.rx_ready;
   // A full RX still accepts the capture when the head leaves in the same cycle.
   assign rx_push = (state == CAPTURE) && (!rx_full || rx_pop);
   assign rx_drop = (state == CAPTURE) && !rx_push;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tx_mem[i] <= '0;
            rx_mem[i] <= '0;
         end
         tx_wr  <= '0;
         tx_rd  <= '0;
         rx_wr  <= '0;
         rx_rd  <= '0;
         tx_cnt <= '0;
         rx_cnt <= '0;
      end else begin
         if (tx_push) begin
            tx_mem[tx_wr] <= bus.tx_data;
            tx_wr         <= tx_wr + 1'b1;
         end
         if (tx_pop)
            tx_rd <= tx_rd + 1'b1;
         if (tx_push && !tx_pop)
            tx_cnt <= tx_cnt + 1'b1;
         else if (!tx_push && tx_pop)
            tx_cnt <= tx_cnt - 1'b1;

         if (rx_push) begin
            rx_mem[rx_wr] <= bus.spi_rx;
            rx_wr         <= rx_wr + 1'b1;
         end
         if (rx_pop)
            rx_rd <= rx_rd + 1'b1;
         if (rx_push && !rx_pop)
            rx_cnt <= rx_cnt + 1'b1;
         else if (!rx_push && rx_pop)
            rx_cnt <= rx_cnt - 1'b1;
      end
   end

   // Set events are assigned after the clear so they take priority over err_clr.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         timer       <= '0;
         spi_start   <= 1'b0;
         spi_data    <= '0;
         rx_overflow <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (bus.err_clr) begin
            rx_overflow <= 1'b0;
            err_timeout <= 1'b0;
         end
         if (rx_drop)
            rx_overflow <= 1'b1;
         case (state)
            IDLE: begin
               if (tx_pop) begin
                  spi_data  <= tx_mem[tx_rd];
                  spi_start <= 1'b1;
                  timer     <= '0;
                  state     <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (bus.spi_busy) begin
                  spi_start <= 1'b0;
                  state     <= WAIT_DONE;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  spi_start   <= 1'b0;
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!bus.spi_busy)
                  state <= CAPTURE;
            end
            CAPTURE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.tx_ready    = !tx_full;
   assign bus.rx_valid    = (rx_cnt != '0);
   assign bus.rx_data     = rx_mem[rx_rd];
   assign bus.spi_data    = spi_data;
   assign bus.spi_start   = spi_start;
   assign bus.rx_overflow = rx_overflow;
   assign bus.err_timeout = err_timeout;
   assign bus.tx_level    = tx_cnt;
   assign bus.rx_level    = rx_cnt;
   assign bus.active      = (state != IDLE);
endmodule

// File: tb/tb_spi_byte_queue.sv
// Bench for spi_byte_queue: loopback engine model plus queue-based expectations.
`timescale 1ns/1ps
module tb_spi_byte_queue;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;
   localparam int LW      = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   spi_byte_queue_if #(.DEPTH(DEPTH)) bus ();

   spi_byte_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Engine model: latches spi_data on a start while idle, stays busy eng_len cycles
   // (random 1..6 when eng_len is 0), then returns the sent byte on spi_rx.
   int         eng_len = 3;
   bit         eng_en  = 1'b1;
   int         launches = 0;
   logic       eng_busy = 1'b0;
   logic [7:0] eng_rx   = 8'h00;
   logic [7:0] eng_sh   = 8'h00;
   int         eng_cnt  = 0;

   assign bus.spi_busy = eng_busy;
   assign bus.spi_rx   = eng_rx;

   always @(posedge clk) begin
      if (!eng_en) begin
         eng_busy <= 1'b0;
      end else if (!eng_busy) begin
         if (bus.spi_start) begin
            eng_busy <= 1'b1;
            eng_sh   <= bus.spi_data;
            eng_cnt  <= (eng_len > 0) ? eng_len : int'($urandom_range(1, 6));
            launches <= launches + 1;
         end
      end else if (eng_cnt > 1) begin
         eng_cnt <= eng_cnt - 1;
      end else begin
         eng_busy <= 1'b0;
         eng_rx   <= eng_sh;
      end
   end

   logic [7:0] exp_q [$];
   logic [7:0] rx_got [$];

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.tx_ready) begin
            bus.tx_data  = b;
            bus.tx_valid = 1'b1;
            @(negedge clk);
            bus.tx_valid = 1'b0;
            return;
         end
      end
   endtask

   task automatic wait_busy(input logic v, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.spi_busy === v) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (bus.tx_level == '0 && !bus.active && !bus.spi_busy) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic drain(input int n, output bit ok);
      rx_got.delete();
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (rx_got.size() == n) begin
            bus.rx_ready = 1'b0;
            ok = 1'b1;
            return;
         end
         bus.rx_ready = 1'b1;
         if (bus.rx_valid) rx_got.push_back(bus.rx_data);
      end
      bus.rx_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_chk++; if (bus.spi_start !== 1'b0) begin n_fail++; $display("FAIL reset_spi_start got=%0h exp=0", bus.spi_start); end
      n_chk++; if (bus.spi_data !== 8'h00) begin n_fail++; $display("FAIL reset_spi_data got=%0h exp=0", bus.spi_data); end
      n_chk++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%0h exp=0", bus.rx_data); end
      n_chk++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%0h exp=0", bus.rx_valid); end
      n_chk++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got=%0h exp=1", bus.tx_ready); end
      n_chk++; if (bus.tx_level !== LW'(0)) begin n_fail++; $display("FAIL reset_tx_level got=%0d exp=0", bus.tx_level); end
      n_chk++; if (bus.rx_level !== LW'(0)) begin n_fail++; $display("FAIL reset_rx_level got=%0d exp=0", bus.rx_level); end
      n_chk++; if (bus.rx_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_rx_overflow got=%0h exp=0", bus.rx_overflow); end
      n_chk++; if (bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err_timeout got=%0h exp=0", bus.err_timeout); end
      n_chk++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%0h exp=0", bus.active); end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_chk++; if (bus.spi_start !== 1'b0) begin n_fail++; $display("FAIL idle_no_start cycle=%0d got=%0h exp=0", i, bus.spi_start); end
      end
   endtask

   task automatic test_single();
      bit ok;
      eng_len = 3;
      send_byte(8'hA5);
      n_chk++; if (bus.spi_start !== 1'b0) begin n_fail++; $display("FAIL single_start_e0 got=%0h exp=0", bus.spi_start); end
      @(negedge clk);
      n_chk++; if (bus.spi_start !== 1'b1) begin n_fail++; $display("FAIL single_start_e1 got=%0h exp=1", bus.spi_start); end
      n_chk++; if (bus.spi_data !== 8'hA5) begin n_fail++; $display("FAIL single_spi_data got=%0h exp=a5", bus.spi_data); end
      n_chk++; if (bus.tx_level !== LW'(0)) begin n_fail++; $display("FAIL single_tx_level got=%0d exp=0", bus.tx_level); end
      @(negedge clk);
      n_chk++; if (bus.spi_start !== 1'b1) begin n_fail++; $display("FAIL single_start_e2 got=%0h exp=1", bus.spi_start); end
      @(negedge clk);
      n_chk++; if (bus.spi_start !== 1'b0) begin n_fail++; $display("FAIL single_start_e3 got=%0h exp=0", bus.spi_start); end
      wait_busy(1'b0, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL single_busy_fall got=timeout exp=fall"); end
      @(negedge clk);
      n_chk++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_rx_valid_ed1 got=%0h exp=0", bus.rx_valid); end
      @(negedge clk);
      n_chk++; if (bus.rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_rx_valid_ed2 got=%0h exp=1", bus.rx_valid); end
      n_chk++; if (bus.rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_rx_data got=%0h exp=a5", bus.rx_data); end
      n_chk++; if (bus.rx_level !== LW'(1)) begin n_fail++; $display("FAIL single_rx_level got=%0d exp=1", bus.rx_level); end
      n_chk++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL single_active got=%0h exp=0", bus.active); end
      drain(1, ok);
   endtask

   task automatic test_burst();
      bit ok;
      int base;
      exp_q.delete();
      eng_len = 30;
      send_byte(8'h00);
      exp_q.push_back(8'h00);
      wait_busy(1'b1, ok);
      base = launches;
      for (int i = 1; i <= 4; i++) begin
         send_byte(8'(i));
         exp_q.push_back(8'(i));
      end
      n_chk++; if (bus.tx_level !== LW'(DEPTH)) begin n_fail++; $display("FAIL burst_tx_level got=%0d exp=%0d", bus.tx_level, DEPTH); end
      n_chk++; if (bus.tx_ready !== 1'b0) begin n_fail++; $display("FAIL burst_tx_ready got=%0h exp=0", bus.tx_ready); end
      bus.tx_data  = 8'h05;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      n_chk++; if (bus.tx_level !== LW'(DEPTH)) begin n_fail++; $display("FAIL burst_full_write got=%0d exp=%0d", bus.tx_level, DEPTH); end
      eng_len = 0;
      drain(5, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL burst_drain got=%0d exp=5", rx_got.size()); end
      for (int i = 0; i < rx_got.size(); i++) begin
         n_chk++; if (rx_got[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_rx[%0d] got=%0h exp=%0h", i, rx_got[i], exp_q[i]); end
      end
      n_chk++; if (launches - base !== 4) begin n_fail++; $display("FAIL burst_launches got=%0d exp=4", launches - base); end
      wait_idle(ok);
   endtask

   task automatic test_overflow();
      bit ok;
      logic [7:0] b [6];
      logic [7:0] popped;
      logic [7:0] exp4 [4];
      for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
      eng_len = 0;
      bus.rx_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(b[i]);
      wait_idle(ok);
      n_chk++; if (bus.rx_level !== LW'(DEPTH)) begin n_fail++; $display("FAIL ovf_rx_level4 got=%0d exp=%0d", bus.rx_level, DEPTH); end
      n_chk++; if (bus.rx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before_5th got=%0h exp=0", bus.rx_overflow); end
      send_byte(b[4]);
      wait_idle(ok);
      n_chk++; if (bus.rx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after_5th got=%0h exp=1", bus.rx_overflow); end
      n_chk++; if (bus.rx_level !== LW'(DEPTH)) begin n_fail++; $display("FAIL ovf_rx_level_kept got=%0d exp=%0d", bus.rx_level, DEPTH); end
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      n_chk++; if (bus.rx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_err_clr got=%0h exp=0", bus.rx_overflow); end
      send_byte(b[5]);
      wait_busy(1'b1, ok);
      wait_busy(1'b0, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL ovf_busy_fall got=timeout exp=fall"); end
      @(negedge clk);
      bus.rx_ready = 1'b1;
      popped = bus.rx_data;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      n_chk++; if (popped !== b[0]) begin n_fail++; $display("FAIL ovf_pop_head got=%0h exp=%0h", popped, b[0]); end
      n_chk++; if (bus.rx_level !== LW'(DEPTH)) begin n_fail++; $display("FAIL ovf_pop_capture_level got=%0d exp=%0d", bus.rx_level, DEPTH); end
      n_chk++; if (bus.rx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pop_capture_flag got=%0h exp=0", bus.rx_overflow); end
      exp4[0] = b[1]; exp4[1] = b[2]; exp4[2] = b[3]; exp4[3] = b[5];
      drain(4, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL ovf_drain got=%0d exp=4", rx_got.size()); end
      for (int i = 0; i < rx_got.size(); i++) begin
         n_chk++; if (rx_got[i] !== exp4[i]) begin n_fail++; $display("FAIL ovf_rx[%0d] got=%0h exp=%0h", i, rx_got[i], exp4[i]); end
      end
   endtask

   task automatic test_timeout();
      eng_en = 1'b0;
      send_byte(8'h5A);
      @(negedge clk);
      n_chk++; if (bus.spi_start !== 1'b1) begin n_fail++; $display("FAIL to_start_rise got=%0h exp=1", bus.spi_start); end
      repeat (TIMEOUT - 1) @(negedge clk);
      n_chk++; if (bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early got=%0h exp=0", bus.err_timeout); end
      n_chk++; if (bus.spi_start !== 1'b1) begin n_fail++; $display("FAIL to_start_held got=%0h exp=1", bus.spi_start); end
      bus.err_clr = 1'b1;
      @(negedge clk);
      n_chk++; if (bus.err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_set_over_clr got=%0h exp=1", bus.err_timeout); end
      n_chk++; if (bus.spi_start !== 1'b0) begin n_fail++; $display("FAIL to_start_drop got=%0h exp=0", bus.spi_start); end
      n_chk++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL to_active got=%0h exp=0", bus.active); end
      n_chk++; if (bus.tx_level !== LW'(0)) begin n_fail++; $display("FAIL to_tx_level got=%0d exp=0", bus.tx_level); end
      n_chk++; if (bus.rx_level !== LW'(0)) begin n_fail++; $display("FAIL to_rx_level got=%0d exp=0", bus.rx_level); end
      @(negedge clk);
      bus.err_clr = 1'b0;
      n_chk++; if (bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clr got=%0h exp=0", bus.err_timeout); end
      eng_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int base;
      eng_len = 10;
      send_byte(8'h3C);
      wait_busy(1'b1, ok);
      @(negedge clk);
      send_byte(8'h77);
      n_chk++; if (bus.active !== 1'b1 || bus.spi_start !== 1'b0) begin n_fail++; $display("FAIL mid_pre active=%0h start=%0h exp=1/0", bus.active, bus.spi_start); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_chk++; if (bus.active !== 1'b0) begin n_fail++; $display("FAIL mid_active got=%0h exp=0", bus.active); end
      n_chk++; if (bus.tx_level !== LW'(0)) begin n_fail++; $display("FAIL mid_tx_level got=%0d exp=0", bus.tx_level); end
      n_chk++; if (bus.rx_level !== LW'(0)) begin n_fail++; $display("FAIL mid_rx_level got=%0d exp=0", bus.rx_level); end
      n_chk++; if (bus.spi_start !== 1'b0) begin n_fail++; $display("FAIL mid_start got=%0h exp=0", bus.spi_start); end
      base = launches;
      wait_busy(1'b0, ok);
      repeat (4) @(negedge clk);
      n_chk++; if (bus.rx_level !== LW'(0) || bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_push level=%0d valid=%0h exp=0/0", bus.rx_level, bus.rx_valid); end
      n_chk++; if (launches !== base) begin n_fail++; $display("FAIL mid_no_launch got=%0d exp=%0d", launches - base, 0); end
   endtask

   task automatic test_random();
      localparam int N = 24;
      int got = 0;
      exp_q.delete();
      eng_len = 0;
      fork
         begin
            for (int k = 0; k < N; k++) begin
               logic [7:0] b;
               b = 8'($urandom);
               for (int t = 0; t < 2000; t++) begin
                  @(negedge clk);
                  if ($urandom_range(0, 2) == 0) begin
                     bus.tx_valid = 1'b0;
                  end else begin
                     bus.tx_data  = b;
                     bus.tx_valid = 1'b1;
                     if (bus.tx_ready) begin
                        exp_q.push_back(b);
                        break;
                     end
                  end
               end
            end
            @(negedge clk);
            bus.tx_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 5000 && got < N; c++) begin
               @(negedge clk);
               bus.rx_ready = (bus.rx_level >= LW'(DEPTH - 1)) ? 1'b1 : 1'($urandom_range(0, 1));
               if (bus.rx_ready && bus.rx_valid) begin
                  logic [7:0] e;
                  e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                  n_chk++; if (bus.rx_data !== e) begin n_fail++; $display("FAIL rand_rx[%0d] got=%0h exp=%0h", got, bus.rx_data, e); end
                  got++;
               end
            end
            bus.rx_ready = 1'b0;
         end
      join
      n_chk++; if (got !== N) begin n_fail++; $display("FAIL rand_count got=%0d exp=%0d", got, N); end
      n_chk++; if (bus.rx_overflow !== 1'b0 || bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL rand_errors ovf=%0h to=%0h exp=0/0", bus.rx_overflow, bus.err_timeout); end
   endtask

   initial begin
      rst          = 1'b1;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      bus.rx_ready = 1'b0;
      bus.err_clr  = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
